// File: rtl/not_unit.sv
// not_unit: registered bitwise inverter with zero/carry flags for the ALU result stage
module not_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             z,
  output logic             cf
);
  logic [WIDTH-1:0] out_d, out_q;
  logic z_d, z_q, cf_d, cf_q, valid_d, valid_q;
  always_comb begin
    out_d   = in_valid ? ~in1 : out_q;
    z_d     = in_valid ? &in1 : z_q;
    cf_d    = 1'b0;
    valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      z_q     <= 1'b0;
      cf_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      z_q     <= z_d;
      cf_q    <= cf_d;
      valid_q <= valid_d;
    end
  end
  assign out       = out_q;
  assign z         = z_q;
  assign cf        = cf_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_not_unit.sv
// tb_not_unit: scoreboard bench for not_unit with an arithmetic reference model
module tb_not_unit;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] out;
  logic out_valid, z, cf;
  typedef struct packed {
    logic [W-1:0] o;
    logic         z;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  logic [W-1:0] last_o = '0;
  logic last_z = 1'b0;

  not_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1),
    .out(out), .out_valid(out_valid), .z(z), .cf(cf)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Inversion of an unsigned W-bit value is its distance from all-ones.
  function automatic exp_t model(logic [W-1:0] d);
    exp_t r;
    r.o = W'(M - int'(d));
    r.z = (int'(d) == M);
    return r;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in1 = d;
    @(posedge clk);
    if (v && rst_n) q.push_back(model(d));
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    q.delete();
    last_o = '0;
    last_z = 1'b0;
    #1;
    chk("async_out", out, 0);
    chk("async_valid", out_valid, 0);
    chk("async_z", z, 0);
    chk("async_cf", cf, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out", out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_z", z, 0);
      chk("rst_cf", cf, 0);
    end else begin
      chk("cf_zero", cf, 0);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("out", out, e.o);
          chk("z", z, e.z);
          last_o = e.o;
          last_z = e.z;
        end
      end else begin
        if (q.size() != 0) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
        chk("hold_out", out, last_o);
        chk("hold_z", z, last_z);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 4'h0);
    step(0, 4'h0);
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(1, 4'b0011);
    step(1, 4'b0111);
    step(1, 4'b1001);
    step(1, 4'b1111);
    step(1, 4'b0011);
    step(0, 4'b1111);
    step(0, 'x);
    step(1, 4'b1111);
    step(1, 4'b1110);
    step(0, 4'h0);
    step(1, 4'b0111);
    @(negedge clk);
    #1 assert_reset();
    in_valid = 1'b1;
    in1 = 4'h5;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 4'b0000);
    step(1, 4'b1001);
    assert_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 4'h0);
    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), W'($urandom));
    step(0, 4'h0);
    step(0, 4'h0);
    @(negedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
